comparator_seq: RTL
===================

Name: comparator_seq

Overview:
- Multi-mode, multi-cycle magnitude/equality comparator for the datapath (branch resolution, set-less-than).
- Successor to the single-cycle combinational equality comparator.
- Compares two N-bit operands SLICE bits per cycle, MSB slice first, with an optional early exit.
- Supports EQ/NE/signed and unsigned LT/GE, with valid/ready handshakes on both the input and output sides.

Parameters:
- N, 32: operand width. Must be a multiple of SLICE.
- SLICE, 8: bits compared per cycle. S = N/SLICE slices; S must be ≥1.
- EARLY_EXIT, 1: 1 = finish on the first differing slice; 0 = always take S compare cycles (constant latency).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  operands and mode are presented.
- i_ready  out  1  block can accept a new operation.
- a  in  N  operand A; signedness is set by mode.
- b  in  N  operand B.
- mode  in  3  000 EQ, 001 NE, 010 LT (signed), 011 GE (signed), 100 LTU, 101 GEU, 110/111 reserved.
- o_valid  out  1  result is valid.
- o_ready  in  1  consumer accepts the result.
- out  out  1  result for the captured mode.
- o_eq  out  1  a == b.
- o_lt  out  1  a < b under the captured signedness; mode 000/001 use unsigned.

Behaviour:
- Reset: asynchronous on rst_n low.
  - State goes to IDLE; i_ready=1 once rst_n is high.
  - o_valid=0, out=0, o_eq=0, o_lt=0.
  - An in-flight operation is discarded with no output.
- FSM states: IDLE, RUN, DONE.
  - IDLE: i_ready=1. On i_valid & i_ready, register a, b, mode; set slice index k=S-1 (top), eq_acc=1, lt_acc=0, decided=0; go to RUN.
  - RUN: i_ready=0. Each cycle compares slice k (bits k*SLICE+SLICE-1 .. k*SLICE) of the captured operands.
    - Top slice in a signed mode (LT/GE): invert the MSB of both slices before the unsigned compare.
    - First differing slice while decided=0: eq_acc=0, lt_acc=(a_slice<b_slice), decided=1.
    - Once decided=1, later slices do not change eq_acc or lt_acc.
    - Go to DONE when k==0, or when the current slice differs and EARLY_EXIT=1. Otherwise decrement k.
  - DONE: o_valid=1; o_eq=eq_acc; o_lt=lt_acc.
    - out per mode: EQ=eq, NE=~eq, LT/LTU=lt, GE/GEU=~lt, reserved=0.
    - Outputs stay stable until o_valid & o_ready. Then go to IDLE with o_valid=0 next cycle.
- Latency: input accept edge to o_valid high.
  - S edges when operands are equal, or when EARLY_EXIT=0.
  - j edges when EARLY_EXIT=1 and the first difference is in slice j counted from the top (j=1 is the MSB slice).
- Throughput: one operation in flight. i_ready is low in RUN and DONE and rises the cycle after the result is consumed; no same-cycle accept on result handoff.
- a, b, mode changes while not in IDLE are ignored; only the captured copies are used.
- S==1: a single RUN cycle, so latency is 1.
- Outputs are registered; no combinational path from the inputs to out, o_eq, or o_lt.

Test Plan:
- N=32, SLICE=8. Accept a=b=0xDEADBEEF, mode EQ → o_valid exactly 4 cycles after accept; out=1, o_eq=1, o_lt=0. Same operands, mode NE → out=0.
- a=0xFFFFFFFF, b=0x00000001:
  - mode LT → out=1, o_lt=1, o_valid 1 cycle after accept (early exit at top slice).
  - mode LTU → out=0.
  - mode GEU → out=1.
- a=0x12345678, b=0x12345679, mode LTU → out=1, o_valid after 4 cycles. Rerun with EARLY_EXIT=0 and case 2 operands → latency is 4, same results.
- Backpressure: result ready, hold o_ready=0 for 10 cycles while toggling a/b/i_valid:
  - o_valid, out, o_eq, o_lt stay stable and i_ready=0.
  - Raise o_ready → o_valid drops next cycle and i_ready=1.
- Reset: drive rst_n low mid-RUN (after 2 slices) → o_valid and outputs are 0 immediately (asynchronous). After release, i_ready=1 and a new op a=0x80000000, b=0x7FFFFFFF, mode LT gives out=1.
- Reserved mode 3'b111 with any operands → completes normally with out=0, and o_eq/o_lt are correct as unsigned.

Source files
------------

// File: rtl/comparator_seq.sv
// Multi-cycle magnitude/equality comparator: walks SLICE bits per cycle from the
// MSB slice down, with optional early exit on the first differing slice.
module comparator_seq #(
    parameter int N          = 32,
    parameter int SLICE      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   mode,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         out,
    output logic         o_eq,
    output logic         o_lt
);

    localparam int S  = N / SLICE;
    localparam int KW = (S > 1) ? $clog2(S) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(S - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [2:0]       r_mode;
    logic [KW-1:0]    r_k;
    logic             r_eq;
    logic             r_lt;
    logic             r_dec;
    logic             r_o_valid;
    logic             r_out;
    logic             r_o_eq;
    logic             r_o_lt;

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic             w_signed;
    logic             w_diff;
    logic             w_eq_n;
    logic             w_lt_n;
    logic             w_last;
    logic             w_out;

    always_comb begin
        w_a_sl   = SLICE'(r_a >> (int'(r_k) * SLICE));
        w_b_sl   = SLICE'(r_b >> (int'(r_k) * SLICE));
        w_signed = (r_mode == 3'b010) || (r_mode == 3'b011);
        // Flipping both sign bits turns the signed top-slice compare into an unsigned one.
        if (w_signed && (r_k == K_TOP)) begin
            w_a_sl[SLICE-1] = ~w_a_sl[SLICE-1];
            w_b_sl[SLICE-1] = ~w_b_sl[SLICE-1];
        end
        w_diff = (w_a_sl != w_b_sl);
        w_eq_n = r_eq;
        w_lt_n = r_lt;
        if (!r_dec && w_diff) begin
            w_eq_n = 1'b0;
            w_lt_n = (w_a_sl < w_b_sl);
        end
        w_last = (r_k == '0) || (w_diff && (EARLY_EXIT != 0));
        case (r_mode)
            3'b000:         w_out = w_eq_n;
            3'b001:         w_out = ~w_eq_n;
            3'b010, 3'b100: w_out = w_lt_n;
            3'b011, 3'b101: w_out = ~w_lt_n;
            default:        w_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_mode    <= '0;
            r_k       <= '0;
            r_eq      <= 1'b1;
            r_lt      <= 1'b0;
            r_dec     <= 1'b0;
            r_o_valid <= 1'b0;
            r_out     <= 1'b0;
            r_o_eq    <= 1'b0;
            r_o_lt    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_mode  <= mode;
                        r_k     <= K_TOP;
                        r_eq    <= 1'b1;
                        r_lt    <= 1'b0;
                        r_dec   <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_eq  <= w_eq_n;
                    r_lt  <= w_lt_n;
                    r_dec <= r_dec | w_diff;
                    if (w_last) begin
                        r_state   <= ST_DONE;
                        r_o_valid <= 1'b1;
                        r_out     <= w_out;
                        r_o_eq    <= w_eq_n;
                        r_o_lt    <= w_lt_n;
                    end else begin
                        r_k <= r_k - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (o_ready) begin
                        r_o_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign i_ready = (r_state == ST_IDLE);
    assign o_valid = r_o_valid;
    assign out     = r_out;
    assign o_eq    = r_o_eq;
    assign o_lt    = r_o_lt;

endmodule
